// File: rtl/dispatcher_pkg.sv
// Shared types and lane layout helpers for the multi-lane activation/weight dispatcher.
package dispatcher_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_W,
        LOAD_ACT,
        EMIT,
        DONE
    } state_e;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_GROUP_SIZE = 4;
    localparam int DEF_NUM_OUT    = 2;

    function automatic int idx_w(input int group_size);
        return (group_size > 1) ? $clog2(group_size) : 1;
    endfunction

    // Lane layout, LSB first: value, weight, element index.
    function automatic int val_ofs();
        return 0;
    endfunction

    function automatic int wgt_ofs(input int data_width);
        return data_width;
    endfunction

    function automatic int idx_ofs(input int data_width);
        return 2 * data_width;
    endfunction

    function automatic int lane_w(input int data_width, input int group_size);
        return 2 * data_width + idx_w(group_size);
    endfunction

    localparam int LANE_W = lane_w(DEF_DATA_WIDTH, DEF_GROUP_SIZE);

endpackage

// File: rtl/dispatcher_mc_if.sv
// Handshake bundle between the group reader, the dispatcher and the MAC array.
interface dispatcher_mc_if
    import dispatcher_pkg::*;
#(
    parameter int DATA_WIDTH             = 8,
    parameter int GROUP_SIZE             = 4,
    parameter int NUM_OUT                = 2,
    parameter int LOG_MAX_ITERS          = 16,
    parameter int LOG_MAX_READS_PER_ITER = 16
);
    localparam int LW = lane_w(DATA_WIDTH, GROUP_SIZE);

    logic                                     configure;
    logic [LOG_MAX_ITERS-1:0]                 num_iters;
    logic [LOG_MAX_READS_PER_ITER-1:0]        num_reads_per_iter;
    logic [DATA_WIDTH*GROUP_SIZE+GROUP_SIZE-1:0] act_data_in;
    logic                                     act_valid_in;
    logic                                     act_avail_out;
    logic [DATA_WIDTH-1:0]                    weight_data_in;
    logic                                     weight_valid_in;
    logic                                     weight_avail_out;
    logic [NUM_OUT*LW-1:0]                    data_out;
    logic [NUM_OUT-1:0]                       lane_valid_out;
    logic                                     valid_out;
    logic                                     avail_in;
    logic                                     done_out;

    modport master (
        output configure, num_iters, num_reads_per_iter,
        output act_data_in, act_valid_in, weight_data_in, weight_valid_in, avail_in,
        input  act_avail_out, weight_avail_out, data_out, lane_valid_out, valid_out, done_out
    );

    modport slave (
        input  configure, num_iters, num_reads_per_iter,
        input  act_data_in, act_valid_in, weight_data_in, weight_valid_in, avail_in,
        output act_avail_out, weight_avail_out, data_out, lane_valid_out, valid_out, done_out
    );

endinterface

// File: rtl/dispatcher_mc_mask_select.sv
// Combinational pick of the NUM_OUT lowest set bits of a pending mask, in ascending order.
module mask_select #(
    parameter int GROUP_SIZE = 4,
    parameter int NUM_OUT    = 2,
    parameter int IDX_W      = 2
) (
    input  logic [GROUP_SIZE-1:0]    mask_i,
    output logic [NUM_OUT*IDX_W-1:0] idx_o,
    output logic [NUM_OUT-1:0]       vld_o,
    output logic [GROUP_SIZE-1:0]    rem_o
);

    logic [GROUP_SIZE-1:0] rem;
    logic [IDX_W-1:0]      pick;
    logic                  found;

    always_comb begin
        idx_o = '0;
        vld_o = '0;
        rem   = mask_i;
        pick  = '0;
        found = 1'b0;
        for (int j = 0; j < NUM_OUT; j++) begin
            found = 1'b0;
            pick  = '0;
            // Descending scan so the last hit is the lowest remaining index.
            for (int k = GROUP_SIZE - 1; k >= 0; k--) begin
                if (rem[k]) begin
                    found = 1'b1;
                    pick  = IDX_W'(k);
                end
            end
            if (found) begin
                vld_o[j]                 = 1'b1;
                idx_o[j*IDX_W +: IDX_W]  = pick;
                rem[pick]                = 1'b0;
            end
        end
        rem_o = rem;
    end

endmodule

// File: rtl/dispatcher_mc.sv
// Multi-lane dispatcher: emits (idx, weight, value) lanes per activation group.
// Define DISPATCHER_ZERO_SKIP_EN to drop masked-zero elements; otherwise every element is emitted.
module dispatcher_mc
    import dispatcher_pkg::*;
#(
    parameter int DATA_WIDTH             = 8,
    parameter int GROUP_SIZE             = 4,
    parameter int NUM_OUT                = 2,
    parameter int LOG_MAX_ITERS          = 16,
    parameter int LOG_MAX_READS_PER_ITER = 16,
    parameter int IDX_W                  = idx_w(GROUP_SIZE)
) (
    input  logic           clk,
    input  logic           rst,
    dispatcher_mc_if.slave bus
);

    localparam int LW    = 2 * DATA_WIDTH + IDX_W;
    localparam int OUT_W = NUM_OUT * LW;
    localparam int GRP_W = DATA_WIDTH * GROUP_SIZE;
    localparam logic [LOG_MAX_ITERS-1:0]          ONE_I = 1;
    localparam logic [LOG_MAX_READS_PER_ITER-1:0] ONE_R = 1;

`ifdef DISPATCHER_ZERO_SKIP_EN
    localparam logic ZERO_SKIP = 1'b1;
`else
    localparam logic ZERO_SKIP = 1'b0;
`endif

    state_e                              state_q, state_d;
    logic [LOG_MAX_ITERS-1:0]            iters_cfg_q, iters_cfg_d;
    logic [LOG_MAX_READS_PER_ITER-1:0]   reads_cfg_q, reads_cfg_d;
    logic [LOG_MAX_ITERS-1:0]            iter_cnt_q, iter_cnt_d;
    logic [LOG_MAX_READS_PER_ITER-1:0]   read_cnt_q, read_cnt_d;
    logic [DATA_WIDTH-1:0]               weight_q, weight_d;
    logic [GRP_W-1:0]                    vals_q, vals_d;
    logic [GROUP_SIZE-1:0]               pend_q, pend_d;
    logic [OUT_W-1:0]                    out_data_q, out_data_d;
    logic [NUM_OUT-1:0]                  lane_vld_q, lane_vld_d;
    logic                                done_q, done_d;

    logic [NUM_OUT*IDX_W-1:0]            sel_idx;
    logic [NUM_OUT-1:0]                  sel_vld;
    logic [GROUP_SIZE-1:0]               sel_rem;
    logic [GROUP_SIZE-1:0]               act_mask;
    logic [GROUP_SIZE-1:0]               pend_load;
    logic                                out_free;
    logic                                grp_end;
    logic                                act_avail;
    logic                                weight_avail;

    mask_select #(
        .GROUP_SIZE (GROUP_SIZE),
        .NUM_OUT    (NUM_OUT),
        .IDX_W      (IDX_W)
    ) u_mask_select (
        .mask_i (pend_q),
        .idx_o  (sel_idx),
        .vld_o  (sel_vld),
        .rem_o  (sel_rem)
    );

    assign act_mask  = bus.act_data_in[GRP_W +: GROUP_SIZE];
    assign pend_load = ~(act_mask & {GROUP_SIZE{ZERO_SKIP}});
    assign out_free  = !(|lane_vld_q) || bus.avail_in;

    always_comb begin
        state_d      = state_q;
        iters_cfg_d  = iters_cfg_q;
        reads_cfg_d  = reads_cfg_q;
        iter_cnt_d   = iter_cnt_q;
        read_cnt_d   = read_cnt_q;
        weight_d     = weight_q;
        vals_d       = vals_q;
        pend_d       = pend_q;
        out_data_d   = out_data_q;
        lane_vld_d   = lane_vld_q;
        done_d       = 1'b0;
        grp_end      = 1'b0;
        act_avail    = 1'b0;
        weight_avail = 1'b0;

        // A drained output register empties unless a new beat is loaded below.
        if (out_free) begin
            out_data_d = '0;
            lane_vld_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (bus.configure) begin
                    iters_cfg_d = bus.num_iters;
                    reads_cfg_d = bus.num_reads_per_iter;
                    iter_cnt_d  = '0;
                    read_cnt_d  = '0;
                    if (bus.num_iters == '0 || bus.num_reads_per_iter == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = WAIT_W;
                    end
                end
            end
            WAIT_W: begin
                weight_avail = 1'b1;
                if (bus.weight_valid_in) begin
                    weight_d   = bus.weight_data_in;
                    read_cnt_d = '0;
                    state_d    = LOAD_ACT;
                end
            end
            LOAD_ACT: begin
                act_avail = out_free;
                if (bus.act_valid_in && out_free) begin
                    vals_d = bus.act_data_in[GRP_W-1:0];
                    pend_d = pend_load;
                    if (pend_load == '0) begin
                        grp_end = 1'b1;
                    end else begin
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (out_free) begin
                    for (int j = 0; j < NUM_OUT; j++) begin
                        lane_vld_d[j] = sel_vld[j];
                        if (sel_vld[j]) begin
                            out_data_d[j*LW +: LW] = {
                                sel_idx[j*IDX_W +: IDX_W],
                                weight_q,
                                vals_q[int'(sel_idx[j*IDX_W +: IDX_W])*DATA_WIDTH +: DATA_WIDTH]
                            };
                        end
                    end
                    pend_d = sel_rem;
                    if (sel_rem == '0) begin
                        grp_end = 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_free) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Compare against count-1 so the counters never need to hold the terminal value.
        if (grp_end) begin
            if (read_cnt_q == reads_cfg_q - ONE_R) begin
                read_cnt_d = '0;
                if (iter_cnt_q == iters_cfg_q - ONE_I) begin
                    iter_cnt_d = '0;
                    state_d    = DONE;
                end else begin
                    iter_cnt_d = iter_cnt_q + ONE_I;
                    state_d    = WAIT_W;
                end
            end else begin
                read_cnt_d = read_cnt_q + ONE_R;
                state_d    = LOAD_ACT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            iters_cfg_q <= '0;
            reads_cfg_q <= '0;
            iter_cnt_q  <= '0;
            read_cnt_q  <= '0;
            weight_q    <= '0;
            vals_q      <= '0;
            pend_q      <= '0;
            out_data_q  <= '0;
            lane_vld_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            iters_cfg_q <= iters_cfg_d;
            reads_cfg_q <= reads_cfg_d;
            iter_cnt_q  <= iter_cnt_d;
            read_cnt_q  <= read_cnt_d;
            weight_q    <= weight_d;
            vals_q      <= vals_d;
            pend_q      <= pend_d;
            out_data_q  <= out_data_d;
            lane_vld_q  <= lane_vld_d;
            done_q      <= done_d;
        end
    end

    assign bus.data_out         = out_data_q;
    assign bus.lane_valid_out   = lane_vld_q;
    assign bus.valid_out        = |lane_vld_q;
    assign bus.done_out         = done_q;
    assign bus.act_avail_out    = act_avail;
    assign bus.weight_avail_out = weight_avail;

endmodule

// File: tb/tb_dispatcher_mc.sv
// Randomized bench for dispatcher_mc against a queue-based beat model.
module tb_dispatcher_mc;

    localparam int DW  = 8;
    localparam int GS  = 4;
    localparam int NO  = 2;
    localparam int IW  = 2;
    localparam int LW  = 2 * DW + IW;
    localparam int OW  = NO * LW;
    localparam int TMO = 300;

`ifdef DISPATCHER_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct {
        logic [OW-1:0] data;
        logic [NO-1:0] lv;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   avail_mode;
    bit   chk_en = 1'b0;
    int   done_cnt = 0;
    int   w_rise = 0;
    logic wa_prev = 1'b0;
    beat_t exp_q[$];
    beat_t got_q[$];

    dispatcher_mc_if #(.DATA_WIDTH(DW), .GROUP_SIZE(GS), .NUM_OUT(NO),
                       .LOG_MAX_ITERS(16), .LOG_MAX_READS_PER_ITER(16)) bus ();

    dispatcher_mc #(.DATA_WIDTH(DW), .GROUP_SIZE(GS), .NUM_OUT(NO),
                    .LOG_MAX_ITERS(16), .LOG_MAX_READS_PER_ITER(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
        n_checks++;
        if (got !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", nm, got, req);
        end
    endtask

    function automatic bit beat_match(input beat_t e, input logic [OW-1:0] d, input logic [NO-1:0] lv);
        if (lv !== e.lv) return 1'b0;
        for (int j = 0; j < NO; j++)
            if (e.lv[j] && d[j*LW +: LW] !== e.data[j*LW +: LW]) return 1'b0;
        return 1'b1;
    endfunction

    // Model: list the surviving elements of a group and cut the list into NO-wide beats.
    function automatic void model_group(input logic [DW-1:0] w, input logic [GS*DW-1:0] vals,
                                        input logic [GS-1:0] mask);
        beat_t b;
        int n = 0;
        b.data = '0;
        b.lv   = '0;
        for (int k = 0; k < GS; k++) begin
            if (!(SKIP && mask[k])) begin
                b.data[n*LW +: LW] = {IW'(k), w, vals[k*DW +: DW]};
                b.lv[n] = 1'b1;
                n++;
                if (n == NO) begin
                    exp_q.push_back(b);
                    b.data = '0;
                    b.lv   = '0;
                    n      = 0;
                end
            end
        end
        if (n > 0) exp_q.push_back(b);
    endfunction

    always @(posedge clk) begin
        #1;
        case (avail_mode)
            0:       bus.avail_in = ($urandom_range(0, 3) != 0);
            1:       bus.avail_in = 1'b0;
            default: bus.avail_in = 1'b1;
        endcase
    end

    // Compare process: every output beat against the model queue.
    always @(negedge clk) begin
        if (bus.done_out === 1'b1) done_cnt++;
        if (bus.weight_avail_out === 1'b1 && wa_prev !== 1'b1) w_rise++;
        wa_prev = bus.weight_avail_out;
        if (chk_en && rst) begin
            chk("valid_or", bus.valid_out, |bus.lane_valid_out);
            chk("avail_excl", bus.act_avail_out & bus.weight_avail_out, 1'b0);
            if (bus.valid_out === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL beat: got data=%h lv=%b, required no beat", bus.data_out, bus.lane_valid_out);
                end else if (!beat_match(exp_q[0], bus.data_out, bus.lane_valid_out)) begin
                    n_errors++;
                    $display("FAIL beat: got data=%h lv=%b, required data=%h lv=%b",
                             bus.data_out, bus.lane_valid_out, exp_q[0].data, exp_q[0].lv);
                end
                if (bus.avail_in === 1'b1) begin
                    beat_t g;
                    g.data = bus.data_out;
                    g.lv   = bus.lane_valid_out;
                    got_q.push_back(g);
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic cfg(input int it, input int rd);
        bus.configure          = 1'b1;
        bus.num_iters          = 16'(it);
        bus.num_reads_per_iter = 16'(rd);
        cyc();
        bus.configure = 1'b0;
    endtask

    task automatic send_weight(input logic [DW-1:0] w);
        int n = 0;
        bus.weight_data_in  = w;
        bus.weight_valid_in = 1'b1;
        while (bus.weight_avail_out !== 1'b1 && n < TMO) begin cyc(); n++; end
        if (n >= TMO) chk("weight_hs_timeout", 1, 0);
        cyc();
        bus.weight_valid_in = 1'b0;
    endtask

    task automatic send_group(input logic [DW-1:0] w, input logic [GS*DW-1:0] vals, input logic [GS-1:0] mask);
        int n = 0;
        model_group(w, vals, mask);
        bus.act_data_in  = {mask, vals};
        bus.act_valid_in = 1'b1;
        while (bus.act_avail_out !== 1'b1 && n < TMO) begin cyc(); n++; end
        if (n >= TMO) chk("act_hs_timeout", 1, 0);
        cyc();
        bus.act_valid_in = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int r0, input int it);
        int n = 0;
        while (done_cnt == d0 && n < TMO) begin cyc(); n++; end
        repeat (3) cyc();
        chk("done_pulses", done_cnt - d0, 1);
        chk("model_drained", exp_q.size(), 0);
        chk("weight_rises", w_rise - r0, it);
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) cyc();
    endtask

    task automatic run_random(input int it, input int rd);
        int d0 = done_cnt;
        int r0 = w_rise;
        logic [DW-1:0] w;
        logic [GS-1:0] m;
        cfg(it, rd);
        for (int i = 0; i < it; i++) begin
            w = DW'($urandom);
            gap();
            send_weight(w);
            for (int r = 0; r < rd; r++) begin
                m = GS'($urandom);
                if ($urandom_range(0, 5) == 0) m = '1;
                gap();
                send_group(w, GS*DW'($urandom), m);
            end
        end
        wait_done(d0, r0, it);
    endtask

    initial begin
        beat_t lit;
        int d0, r0, g0, n;
        logic [OW-1:0] hold;

        rst = 1'b0;
        avail_mode = 2;
        bus.configure = 1'b0;
        bus.num_iters = '0;
        bus.num_reads_per_iter = '0;
        bus.act_data_in = '0;
        bus.act_valid_in = 1'b0;
        bus.weight_data_in = '0;
        bus.weight_valid_in = 1'b0;
        bus.avail_in = 1'b1;
        repeat (3) cyc();
        chk("rst_valid", bus.valid_out, 0);
        chk("rst_lanes", bus.lane_valid_out, 0);
        chk("rst_data", bus.data_out, 0);
        chk("rst_done", bus.done_out, 0);
        chk("rst_act_avail", bus.act_avail_out, 0);
        chk("rst_w_avail", bus.weight_avail_out, 0);
        rst = 1'b1;
        chk_en = 1'b1;
        cyc();

        // Single group {0,1,2,2}, mask 0001, weight 5.
        d0 = done_cnt; r0 = w_rise; g0 = got_q.size();
        cfg(1, 1);
        send_weight(8'd5);
        send_group(8'd5, {8'd2, 8'd2, 8'd1, 8'd0}, 4'b0001);
        wait_done(d0, r0, 1);
        chk("t1_beats", got_q.size() - g0, 2);
        if (got_q.size() >= g0 + 2) begin
            if (SKIP) begin
                lit.data = {2'd2, 8'd5, 8'd2, 2'd1, 8'd5, 8'd1}; lit.lv = 2'b11;
                chk("t1_beat0", beat_match(lit, got_q[g0].data, got_q[g0].lv), 1);
                lit.data = {18'd0, 2'd3, 8'd5, 8'd2};            lit.lv = 2'b01;
                chk("t1_beat1", beat_match(lit, got_q[g0+1].data, got_q[g0+1].lv), 1);
            end else begin
                lit.data = {2'd1, 8'd5, 8'd1, 2'd0, 8'd5, 8'd0}; lit.lv = 2'b11;
                chk("t1_beat0", beat_match(lit, got_q[g0].data, got_q[g0].lv), 1);
                lit.data = {2'd3, 8'd5, 8'd2, 2'd2, 8'd5, 8'd2}; lit.lv = 2'b11;
                chk("t1_beat1", beat_match(lit, got_q[g0+1].data, got_q[g0+1].lv), 1);
            end
        end

        // Two iterations of four reads, groups {0,i,i+1,i+1}.
        avail_mode = 0;
        d0 = done_cnt; r0 = w_rise; g0 = got_q.size();
        cfg(2, 4);
        for (int it = 0; it < 2; it++) begin
            send_weight(DW'(it + 1));
            for (int i = 0; i < 4; i++)
                send_group(DW'(it + 1), {DW'(i + 1), DW'(i + 1), DW'(i), 8'd0}, 4'b0001);
        end
        wait_done(d0, r0, 2);
        chk("t2_beats", got_q.size() - g0, 16);

        // All-zero group followed by a dense one.
        avail_mode = 2;
        d0 = done_cnt; r0 = w_rise; g0 = got_q.size();
        cfg(1, 2);
        send_weight(8'd7);
        send_group(8'd7, 32'h11223344, 4'b1111);
        if (SKIP) begin
            n = 0;
            while (bus.act_avail_out !== 1'b1 && n < 2) begin cyc(); n++; end
            chk("zero_grp_reavail", bus.act_avail_out, 1);
        end
        send_group(8'd7, 32'h0a0b0c0d, 4'b0000);
        wait_done(d0, r0, 1);
        chk("t3_beats", got_q.size() - g0, SKIP ? 2 : 4);

        // Downstream stall on the first beat.
        avail_mode = 1;
        d0 = done_cnt; r0 = w_rise; g0 = got_q.size();
        cfg(1, 1);
        send_weight(8'd3);
        send_group(8'd3, 32'h04030201, 4'b0000);
        n = 0;
        while (bus.valid_out !== 1'b1 && n < TMO) begin cyc(); n++; end
        chk("stall_valid", bus.valid_out, 1);
        hold = bus.data_out;
        repeat (5) begin
            cyc();
            chk("stall_data", bus.data_out, hold);
            chk("stall_act_avail", bus.act_avail_out, 0);
        end
        avail_mode = 2;
        wait_done(d0, r0, 1);
        chk("stall_beats", got_q.size() - g0, 2);

        // Zero configuration finishes immediately.
        d0 = done_cnt; r0 = w_rise;
        cfg(0, 3);
        wait_done(d0, r0, 0);

        // Reset while emitting.
        avail_mode = 1;
        cfg(1, 1);
        send_weight(8'd9);
        send_group(8'd9, 32'h05060708, 4'b0000);
        n = 0;
        while (bus.valid_out !== 1'b1 && n < TMO) begin cyc(); n++; end
        rst = 1'b0;
        cyc();
        chk("mid_rst_valid", bus.valid_out, 0);
        chk("mid_rst_lanes", bus.lane_valid_out, 0);
        chk("mid_rst_data", bus.data_out, 0);
        chk("mid_rst_done", bus.done_out, 0);
        chk("mid_rst_act_avail", bus.act_avail_out, 0);
        rst = 1'b1;
        exp_q.delete();
        avail_mode = 2;
        bus.weight_valid_in = 1'b1;
        repeat (4) begin
            cyc();
            chk("no_cfg_w_avail", bus.weight_avail_out, 0);
        end
        bus.weight_valid_in = 1'b0;

        // Group {0,3,0,4}, mask 0101.
        d0 = done_cnt; r0 = w_rise; g0 = got_q.size();
        cfg(1, 1);
        send_weight(8'd9);
        send_group(8'd9, {8'd4, 8'd0, 8'd3, 8'd0}, 4'b0101);
        wait_done(d0, r0, 1);
        if (SKIP) begin
            chk("t6_beats", got_q.size() - g0, 1);
            lit.data = {2'd3, 8'd9, 8'd4, 2'd1, 8'd9, 8'd3}; lit.lv = 2'b11;
            if (got_q.size() > g0) chk("t6_beat0", beat_match(lit, got_q[g0].data, got_q[g0].lv), 1);
        end else begin
            chk("t6_beats", got_q.size() - g0, 2);
            lit.data = {2'd1, 8'd9, 8'd3, 2'd0, 8'd9, 8'd0}; lit.lv = 2'b11;
            if (got_q.size() > g0) chk("t6_beat0", beat_match(lit, got_q[g0].data, got_q[g0].lv), 1);
            lit.data = {2'd3, 8'd9, 8'd4, 2'd2, 8'd9, 8'd0}; lit.lv = 2'b11;
            if (got_q.size() > g0 + 1) chk("t6_beat1", beat_match(lit, got_q[g0+1].data, got_q[g0+1].lv), 1);
        end

        // Randomized runs with random downstream backpressure.
        avail_mode = 0;
        for (int r = 0; r < 6; r++)
            run_random($urandom_range(1, 3), $urandom_range(1, 4));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dispatcher_mc.md
Name: dispatcher_mc

Overview:
- Multi-lane successor of the single-output activation/weight dispatcher. Sits between the activation group reader and the MAC array.
- Accepts one weight per iteration and, per iteration, num_reads_per_iter activation groups of GROUP_SIZE values, each with a per-element zero mask.
- Emits only the non-zero elements, up to NUM_OUT per cycle, packed into lanes. Each element is tagged with the iteration weight and its position in the group.

Parameters:
- DATA_WIDTH, 8, bits per activation and per weight.
- GROUP_SIZE, 4, activation elements per input group; zero mask width.
- NUM_OUT, 2, output lanes per cycle (1..GROUP_SIZE).
- LOG_MAX_ITERS, 16, width of num_iters.
- LOG_MAX_READS_PER_ITER, 16, width of num_reads_per_iter.
- IDX_W, $clog2(GROUP_SIZE), element index width (minimum 1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- configure  in  1  latch run configuration (honoured in IDLE only).
- num_iters  in  LOG_MAX_ITERS  iterations (weights) per run.
- num_reads_per_iter  in  LOG_MAX_READS_PER_ITER  activation groups per iteration.
- act_data_in  in  DATA_WIDTH*GROUP_SIZE+GROUP_SIZE  {zero_mask, values}; element k at [k*DATA_WIDTH+:DATA_WIDTH]; mask bit k=1 means element k is zero.
- act_valid_in  in  1  activation group valid.
- act_avail_out  out  1  dispatcher can take a group.
- weight_data_in  in  DATA_WIDTH  iteration weight.
- weight_valid_in  in  1  weight valid.
- weight_avail_out  out  1  dispatcher can take a weight.
- data_out  out  NUM_OUT*(2*DATA_WIDTH+IDX_W)  lane j = {idx, weight, value}.
- lane_valid_out  out  NUM_OUT  per-lane valid; contiguous from lane 0.
- valid_out  out  1  OR of lane_valid_out.
- avail_in  in  1  downstream can accept.
- done_out  out  1  one-cycle pulse at end of run.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-low. rst=0 at any clock edge, including mid-run, forces:
  - state IDLE; all counters, pending mask and output registers to 0;
  - valid_out=0, lane_valid_out=0, data_out=0, done_out=0, act_avail_out=0, weight_avail_out=0.
- Handshakes:
  - Activation transfer: act_valid_in && act_avail_out.
  - Weight transfer: weight_valid_in && weight_avail_out.
  - Output transfer: valid_out && avail_in. While valid_out && !avail_in, data_out and lane_valid_out hold stable.
- State IDLE:
  - On configure=1, latch num_iters and num_reads_per_iter.
  - If either value is 0: pulse done_out next cycle and stay in IDLE.
  - Otherwise go to WAIT_W.
  - configure in any other state is ignored.
- State WAIT_W:
  - weight_avail_out=1.
  - On transfer, register the weight, clear the read counter, go to LOAD_ACT.
- State LOAD_ACT:
  - act_avail_out=1, and only when the output register is empty or being drained this cycle.
  - On transfer, pending mask = ~zero_mask and the group values are registered.
  - If the pending mask is all-zero (every element is zero), the group counts as consumed with no output; go directly to the end-of-group step.
  - Otherwise go to EMIT.
- State EMIT:
  - Each cycle the output register is free, select the lowest-index set bits of the pending mask, up to NUM_OUT of them.
  - Load them into lanes 0..n-1 in ascending index and clear them from the mask.
  - The next load happens only after the current output transfers.
  - When the mask empties after a load, take the end-of-group step.
- End-of-group step: increment the read counter.
  - If reads == num_reads_per_iter: increment the iteration counter; if iters == num_iters, go to DONE, otherwise go to WAIT_W.
  - Otherwise go to LOAD_ACT.
- State DONE:
  - Wait until the last output has transferred.
  - Pulse done_out for one cycle and return to IDLE.
- Latency: a group accepted at edge N has its first output valid after edge N+1.
- Throughput: at most one group is in flight, so there is one bubble cycle per group (the LOAD_ACT cycle).
- Counter widths match the parameters; the maximum counts (2^W-1) must not wrap.

Optional Feature:
- DISPATCHER_ZERO_SKIP_EN defined: zero-mask skipping exactly as described above.
- Undefined: the zero mask is ignored and the pending mask loads as all ones. Every element is emitted in index order, NUM_OUT per cycle, zeros included.

Decomposition:
- Package dispatcher_pkg holds:
  - state enum {IDLE, WAIT_W, LOAD_ACT, EMIT, DONE};
  - lane field offsets and LANE_W = 2*DATA_WIDTH+IDX_W.
- Sub-module mask_select: combinational pick of the NUM_OUT lowest set bits from a GROUP_SIZE mask. Outputs per-lane index, per-lane valid, and the remaining mask.

Test Plan (GROUP_SIZE=4, NUM_OUT=2, DATA_WIDTH=8, skip enabled unless noted):
- Config iters=1, reads=1; weight 5; group values {0,1,2,2} mask 0001 -> beat 1: lanes (1,5,idx1),(2,5,idx2), lane_valid 11; beat 2: (2,5,idx3), lane_valid 01; then done_out pulse.
- Iters=2, reads=4, weights 1,2; groups {0,i,i+1,i+1} -> exactly 3 elements per group (i=0 gives value 0 at idx1 with mask bit clear, which is still emitted). Weight field is 1 for the first four groups and 2 for the last four; weight_avail_out rises exactly twice.
- Group all-zero, mask 1111 -> no valid_out beat; act_avail_out high again within 2 cycles; read counter advances.
- avail_in held low 5 cycles during the first beat -> data_out stable, no loss or duplication; act_avail_out stays low.
- rst=0 while in EMIT -> next cycle all outputs 0, state IDLE; configure required to restart.
- DISPATCHER_ZERO_SKIP_EN undefined, group {0,3,0,4} -> beats (0,idx0),(3,idx1) then (0,idx2),(4,idx3).
